fc_seq_ctrl: RTL and testbench
==============================

// Module: fc_seq_ctrl
// PURPOSE
// Control FSM for the fully-connected layer datapath. Gives one M-entry vector memory, P parallel
// weight ROMs and P MAC units a fixed schedule:
// - load M inputs;
// - for each of N/P output groups: clear, accumulate M products, then emit P results in order.
// Holds no data. Drives addresses, enables and selects, and owns both valid/ready handshakes.
// PARAMETERS
// M       8  input vector length (>=2)
// N       16 output vector length (N % P == 0 required)
// P       2  parallel MAC units (>=1)
// RD_LAT  1  cycles from rd_en/address to operands valid at the MAC inputs (>=1)
// ACC_LAT 1  cycles from mac_en to the updated accumulator being visible (>=1)
// PORTS
// clk          in  1                    clock, rising edge
// reset        in  1                    asynchronous, active-low reset (0 = in reset)
// input_valid  in  1                    upstream word valid
// input_ready  out 1                    upstream word accepted when valid&&ready
// x_wr_en      out 1                    write input_data into vector memory at x_addr
// x_addr       out max(1,$clog2(M))     vector memory address (shared write/read)
// rd_en        out 1                    read vector memory and all P weight ROMs this cycle
// w_addr       out $clog2(M*N/P)        weight ROM address = grp*M + k
// mac_clr      out 1                    zero all P accumulators
// mac_en       out 1                    accumulate the current product in all P MACs
// out_sel      out max(1,$clog2(P))     MAC index driving output_data
// output_valid out 1                    downstream result valid
// output_ready in  1                    downstream accepts when valid&&ready
// BEHAVIOUR
// - Reset (reset==0): immediate and asynchronous.
//   - State=LOAD; counters k, grp, sel = 0; mac_en pipeline cleared.
//   - All outputs 0 except input_ready=0 while in reset.
//   - The first cycle after release is LOAD with input_ready=1.
// - Reset mid-operation: the partial vector and all results are abandoned; no output_valid follows.
// - LOAD state:
//   - input_ready=1; x_wr_en=input_valid; x_addr=k.
//   - k increments on each handshake.
//   - On the M-th handshake: k<=0 and next state is CLEAR; input_ready=0 from the following cycle.
// - CLEAR state: mac_clr=1 for exactly 1 cycle, then MAC.
// - MAC state, M cycles:
//   - rd_en=1; x_addr=k; w_addr=grp*M+k; k 0..M-1.
//   - After k==M-1: k<=0, next state WAIT.
// - mac_en: rd_en delayed by exactly RD_LAT cycles (shift register). Never high together with mac_clr.
// - WAIT state:
//   - Lasts RD_LAT+ACC_LAT-1 cycles (0 cycles means MAC goes directly to OUT).
//   - Drains mac_en; then OUT.
// - OUT state:
//   - output_valid=1; out_sel=sel.
//   - sel advances only on output_valid&&output_ready. Otherwise output_valid and out_sel are held
//     stable; no drop and no change.
//   - On the P-th handshake: sel<=0, grp<=grp+1.
//   - If grp was N/P-1: grp<=0, next state LOAD; otherwise next state CLEAR.
// - Inputs in non-LOAD states: input_valid is ignored (input_ready=0, x_wr_en=0).
// - Outputs in non-OUT states: output_ready is ignored.
// - Throughput with valid/ready always high:
//   - M + (N/P)*(1 + M + RD_LAT+ACC_LAT-1 + P) cycles per vector.
//   - Defaults: 8 + 8*12 = 104 cycles.
// - Counter widths: sized for max value; wrap never occurs because every terminal count is explicit.
// - All outputs are registered state decodes or the mac_en shift register; no combinational path
//   from input_valid or output_ready to any output except x_wr_en.
// CONFIGURATION
// - FC_SEQ_CTRL_PERF_EN defined:
//   - Adds output stall_cnt[31:0].
//   - Counts cycles with output_valid&&!output_ready.
//   - Cleared only by reset; saturates at 32'hFFFFFFFF.
// - Undefined: no stall_cnt port and no counter logic.
// TESTING (defaults M=8,N=16,P=2,RD_LAT=1,ACC_LAT=1)
// 1. Reset release; input_valid=1 and output_ready=1 continuously:
//    - input_ready high exactly 8 cycles with x_addr 0..7.
//    - mac_clr at cycle 8, rd_en cycles 9-16, mac_en cycles 10-17.
//    - output_valid cycles 18-19 with out_sel 0,1.
// 2. Same run:
//    - Group 3 MAC phase shows w_addr 24..31 with x_addr 0..7.
//    - Last output (grp 7, sel 1) at cycle 103; input_ready=1 at cycle 104.
// 3. output_ready=0 for 5 cycles in the first OUT:
//    - output_valid stays 1 and out_sel stays 0.
//    - stall_cnt==5 with the macro defined.
// 4. input_valid toggling 1,0,1,0...:
//    - x_addr/x_wr_en advance only on handshake cycles.
//    - input_ready drops after the 8th accept (cycle 15).
//    - Output sequence is identical to scenario 1, shifted by 7 cycles.
// 5. reset=0 asserted mid-MAC (grp 2, k 4):
//    - rd_en, mac_en and output_valid fall immediately.
//    - After release: LOAD, x_addr=0, grp=0; no stale output_valid ever appears.
// 6. Two back-to-back vectors with random valid/ready:
//    - Exactly 32 output handshakes; out_sel alternates 0,1.
//    - mac_clr precedes every group; mac_en never overlaps mac_clr.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: schedule controller for the fully-connected layer datapath (load, clear, MAC, drain, emit).
// Define FC_SEQ_CTRL_PERF_EN to add the saturating output-stall counter stall_cnt.
module fc_seq_ctrl #(
    parameter int M       = 8,
    parameter int N       = 16,
    parameter int P       = 2,
    parameter int RD_LAT  = 1,
    parameter int ACC_LAT = 1,
    localparam int XW     = (M > 1) ? $clog2(M) : 1,
    localparam int WW     = $clog2(M * N / P),
    localparam int SW     = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    output logic          x_wr_en,
    output logic [XW-1:0] x_addr,
    output logic          rd_en,
    output logic [WW-1:0] w_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [SW-1:0] out_sel,
    output logic          output_valid,
    input  logic          output_ready
`ifdef FC_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int GRPS     = N / P;
    localparam int GW       = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int WAIT_CYC = RD_LAT + ACC_LAT - 1;
    localparam int WCW      = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_MAC,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              armed;
    logic [XW-1:0]     k;
    logic [GW-1:0]     grp;
    logic [SW-1:0]     sel;
    logic [WCW-1:0]    wcnt;
    logic [RD_LAT-1:0] rd_pipe;

    logic in_hs;
    logic out_hs;
    logic k_last;
    logic wait_last;
    logic sel_last;
    logic grp_last;

    assign k_last    = (k == XW'(M - 1));
    assign wait_last = (wcnt == WCW'(WAIT_CYC - 1));
    assign sel_last  = (sel == SW'(P - 1));
    assign grp_last  = (grp == GW'(GRPS - 1));

    // armed keeps input_ready low while in reset even though the state register already reads LOAD.
    assign input_ready  = armed && (state == S_LOAD);
    assign x_wr_en      = input_ready && input_valid;
    assign x_addr       = k;
    assign rd_en        = (state == S_MAC);
    assign w_addr       = rd_en ? WW'(int'(grp) * M + int'(k)) : '0;
    assign mac_clr      = (state == S_CLEAR);
    assign mac_en       = rd_pipe[RD_LAT-1];
    assign output_valid = (state == S_OUT);
    assign out_sel      = sel;

    assign in_hs  = x_wr_en;
    assign out_hs = output_valid && output_ready;

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:  if (in_hs && k_last) next_state = S_CLEAR;
            S_CLEAR: next_state = S_MAC;
            S_MAC:   if (k_last) next_state = (WAIT_CYC == 0) ? S_OUT : S_WAIT;
            S_WAIT:  if (wait_last) next_state = S_OUT;
            S_OUT:   if (out_hs && sel_last) next_state = grp_last ? S_LOAD : S_CLEAR;
            default: next_state = S_LOAD;
        endcase
    end

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_LOAD;
            armed   <= 1'b0;
            k       <= '0;
            grp     <= '0;
            sel     <= '0;
            wcnt    <= '0;
            rd_pipe <= '0;
        end else begin
            state   <= next_state;
            armed   <= 1'b1;
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_en);
            case (state)
                S_LOAD: begin
                    if (in_hs) k <= k_last ? '0 : k + 1'b1;
                end
                S_MAC: begin
                    k <= k_last ? '0 : k + 1'b1;
                end
                S_WAIT: begin
                    wcnt <= wait_last ? '0 : wcnt + 1'b1;
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (sel_last) begin
                            sel <= '0;
                            grp <= grp_last ? '0 : grp + 1'b1;
                        end else begin
                            sel <= sel + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FC_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (output_valid && !output_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: vector table plus address/result-order scoreboard for fc_seq_ctrl at default parameters.
// Build with FC_SEQ_CTRL_PERF_EN defined to also check stall_cnt.
module tb_fc_seq_ctrl;

    localparam int M    = 8;
    localparam int N    = 16;
    localparam int P    = 2;
    localparam int GRPS = N / P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       input_valid = 1'b0;
    logic       output_ready = 1'b0;
    logic       input_ready;
    logic       x_wr_en;
    logic [2:0] x_addr;
    logic       rd_en;
    logic [5:0] w_addr;
    logic       mac_clr;
    logic       mac_en;
    logic [0:0] out_sel;
    logic       output_valid;
`ifdef FC_SEQ_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fc_seq_ctrl #(.M(M), .N(N), .P(P), .RD_LAT(1), .ACC_LAT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .x_wr_en      (x_wr_en),
        .x_addr       (x_addr),
        .rd_en        (rd_en),
        .w_addr       (w_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .out_sel      (out_sel),
        .output_valid (output_valid),
        .output_ready (output_ready)
`ifdef FC_SEQ_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    int         exp_wr;
    int         out_hs;
    int         clr_cnt;
    logic       prev_rd;
    logic       prev_clr;
    logic [8:0] rd_q[$];
    logic [0:0] sel_q[$];

    typedef struct {
        int          cyc;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] outs();
        return {input_ready, x_wr_en, x_addr, rd_en, w_addr, mac_clr, mac_en, output_valid, out_sel};
    endfunction

    function automatic logic [15:0] mk(input logic ir, input logic xwe, input logic [2:0] xa,
                                       input logic rd, input logic [5:0] wa, input logic clr,
                                       input logic me, input logic ov, input logic [0:0] os);
        return {ir, xwe, xa, rd, wa, clr, me, ov, os};
    endfunction

    task automatic sb_reset();
        rd_q.delete();
        sel_q.delete();
        exp_wr   = 0;
        out_hs   = 0;
        clr_cnt  = 0;
        prev_rd  = 1'b0;
        prev_clr = 1'b0;
    endtask

    // One cycle: drive inputs on the falling edge, let them settle, then score the outputs.
    task automatic tick(input logic iv, input logic ordy);
        logic [8:0] e_rd;
        logic [0:0] e_sel;
        @(negedge clk);
        input_valid  = iv;
        output_ready = ordy;
        #1;
        if (x_wr_en) begin
            check("wr_addr", 32'(x_addr), 32'(exp_wr));
            exp_wr++;
            if (exp_wr == M) begin
                exp_wr = 0;
                for (int g = 0; g < GRPS; g++)
                    for (int kk = 0; kk < M; kk++)
                        rd_q.push_back({3'(kk), 6'(g * M + kk)});
                for (int g = 0; g < GRPS; g++)
                    for (int s = 0; s < P; s++)
                        sel_q.push_back(1'(s));
            end
        end
        if (rd_en) begin
            check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) begin
                e_rd = rd_q.pop_front();
                check("rd_addr", 32'({x_addr, w_addr}), 32'(e_rd));
            end
            if (!prev_rd) check("clr_before_grp", 32'(prev_clr), 32'd1);
        end
        if (mac_clr) begin
            clr_cnt++;
            check("clr_mac_overlap", 32'(mac_en), 32'd0);
        end
        if (output_valid && ordy) begin
            out_hs++;
            check("out_expected", 32'(sel_q.size() > 0), 32'd1);
            if (sel_q.size() > 0) begin
                e_sel = sel_q.pop_front();
                check("out_sel_order", 32'(out_sel), 32'(e_sel));
            end
        end
        prev_rd  = rd_en;
        prev_clr = mac_clr;
    endtask

    // Hold reset with both handshake inputs high, check the idle outputs, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb_reset();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[15];
        int   ti;
        int   c;
        int   ov_early;

        tbl[0]  = '{0,   mk(1, 1, 0, 0, 0,  0, 0, 0, 0)};
        tbl[1]  = '{7,   mk(1, 1, 7, 0, 0,  0, 0, 0, 0)};
        tbl[2]  = '{8,   mk(0, 0, 0, 0, 0,  1, 0, 0, 0)};
        tbl[3]  = '{9,   mk(0, 0, 0, 1, 0,  0, 0, 0, 0)};
        tbl[4]  = '{10,  mk(0, 0, 1, 1, 1,  0, 1, 0, 0)};
        tbl[5]  = '{16,  mk(0, 0, 7, 1, 7,  0, 1, 0, 0)};
        tbl[6]  = '{17,  mk(0, 0, 0, 0, 0,  0, 1, 0, 0)};
        tbl[7]  = '{18,  mk(0, 0, 0, 0, 0,  0, 0, 1, 0)};
        tbl[8]  = '{19,  mk(0, 0, 0, 0, 0,  0, 0, 1, 1)};
        tbl[9]  = '{20,  mk(0, 0, 0, 0, 0,  1, 0, 0, 0)};
        tbl[10] = '{21,  mk(0, 0, 0, 1, 8,  0, 0, 0, 0)};
        tbl[11] = '{45,  mk(0, 0, 0, 1, 24, 0, 0, 0, 0)};
        tbl[12] = '{52,  mk(0, 0, 7, 1, 31, 0, 1, 0, 0)};
        tbl[13] = '{103, mk(0, 0, 0, 0, 0,  0, 0, 1, 1)};
        tbl[14] = '{104, mk(1, 1, 0, 0, 0,  0, 0, 0, 0)};

        sb_reset();

        // Free-running vector: timeline checked against the table.
        do_reset();
        ti = 0;
        for (int cy = 0; cy <= 104; cy++) begin
            tick(1'b1, 1'b1);
            if (ti < 15 && tbl[ti].cyc == cy) begin
                check($sformatf("vec%0d_cyc%0d", ti, cy), 32'(outs()), 32'(tbl[ti].exp));
                ti++;
            end
        end
        check("s1_out_count", 32'(out_hs), 32'(N));

        // Downstream stall during the first result.
        do_reset();
        for (int cy = 0; cy <= 109; cy++) begin
            if (cy >= 18 && cy <= 22) begin
                tick(1'b1, 1'b0);
                check($sformatf("stall_hold_cyc%0d", cy), 32'({output_valid, out_sel}), 32'b10);
            end else begin
                tick(1'b1, 1'b1);
            end
            if (cy == 23) check("stall_release_sel0", 32'({output_valid, out_sel}), 32'b10);
            if (cy == 24) check("stall_release_sel1", 32'({output_valid, out_sel}), 32'b11);
            if (cy == 108) check("stall_last_out", 32'({output_valid, out_sel}), 32'b11);
            if (cy == 109) check("stall_reload", 32'(input_ready), 32'd1);
        end
        check("s3_out_count", 32'(out_hs), 32'(N));
`ifdef FC_SEQ_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, 32'd5);
`endif

        // Upstream valid toggling every cycle.
        do_reset();
        for (int cy = 0; cy <= 111; cy++) begin
            tick((cy % 2) == 0, 1'b1);
            if (cy == 1)   check("tog_no_wr", 32'({input_ready, x_wr_en, x_addr}), 32'b10_001);
            if (cy == 14)  check("tog_8th_accept", 32'({input_ready, x_wr_en, x_addr}), 32'b11_111);
            if (cy == 15)  check("tog_ready_drop", 32'({input_ready, mac_clr}), 32'b01);
            if (cy == 25)  check("tog_first_out", 32'({output_valid, out_sel}), 32'b10);
            if (cy == 26)  check("tog_second_out", 32'({output_valid, out_sel}), 32'b11);
            if (cy == 110) check("tog_last_out", 32'({output_valid, out_sel}), 32'b11);
            if (cy == 111) check("tog_reload", 32'({input_ready, output_valid}), 32'b10);
        end
        check("s4_out_count", 32'(out_hs), 32'(N));

        // Asynchronous reset in the middle of group 2's MAC phase.
        do_reset();
        for (int cy = 0; cy <= 37; cy++) tick(1'b1, 1'b1);
        check("mid_mac_pre", 32'({rd_en, mac_en, x_addr, w_addr}), 32'({1'b1, 1'b1, 3'd4, 6'd20}));
        #2;
        reset = 1'b0;
        #1;
        check("mid_mac_async", 32'({rd_en, mac_en, output_valid, input_ready}), 32'd0);
        do_reset();
        ov_early = 0;
        for (int cy = 0; cy <= 104; cy++) begin
            tick(1'b1, 1'b1);
            if (cy < 18 && output_valid) ov_early++;
            if (cy == 0) check("post_reset_load", 32'({input_ready, x_addr}), 32'b1_000);
        end
        check("post_reset_no_stale_ov", 32'(ov_early), 32'd0);
        check("s5_out_count", 32'(out_hs), 32'(N));

        // Two vectors with random handshakes.
        do_reset();
        c = 0;
        while (out_hs < 2 * N && c < 3000) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            c++;
        end
        check("rand_out_count", 32'(out_hs), 32'(2 * N));
        check("rand_clr_count", 32'(clr_cnt), 32'(2 * GRPS));
        check("rand_rd_drained", 32'(rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
